jtag_axi_txn_ctrl: RTL and testbench
====================================

# jtag_axi_txn_ctrl

Single-clock request sequencer between the JTAG data-register front end and the request/response FIFOs of the JTAG-to-AXI bridge. It accepts one decoded request at a time and pushes it atomically into the transaction FIFO, plus the write-data FIFO for writes. It then waits for the matching entry in the response FIFO and publishes status, read data and a completion count. A watchdog converts a missing response into a TIMEOUT status and discards the late response when it eventually arrives.

## Interface
- `AXI_TIMEOUT_CYCLES`, default 4096: cycles spent in WAIT_RESP before timeout; 0 disables the watchdog.
- `DROP_CNT_W`, default 4: width of the late-response discard counter.

- `clk`  in  1  clock
- `ares`  in  1  asynchronous, active-high reset
- `req_valid_i`  in  1  request strobe, already synchronised to `clk`
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`
- `req_write_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  axi_addr_t  target address
- `req_size_i`  in  axi_size_t  AXI size
- `req_data_i`  in  axi_data_t  write data
- `fifo_txn_full_i`  in  1  transaction FIFO full
- `fifo_txn_wr_en_o`  out  1  transaction FIFO push
- `fifo_txn_o`  out  s_axi_afifo_to_axi_t  carries `{addr, size, txn_type}`
- `fifo_wdata_full_i`  in  1  write-data FIFO full
- `fifo_wdata_wr_en_o`  out  1  write-data FIFO push
- `fifo_wdata_o`  out  axi_data_t  write data
- `fifo_resp_empty_i`  in  1  response FIFO empty
- `fifo_resp_i`  in  s_axi_jtag_status_t  head entry, `{data_rd, status}`
- `fifo_resp_rd_en_o`  out  1  response FIFO pop
- `status_o`  out  jtag_axi_status_t  last transaction status
- `rdata_o`  out  axi_data_t  last read data
- `busy_o`  out  1  state is not IDLE
- `timeout_o`  out  1  sticky timeout flag
- `txn_cnt_o`  out  16  completed-transaction count

## Operation
- **Reset values:**
  - State IDLE, `status_o` = JTAG_AXI_IDLE.
  - `rdata_o` = 0, `busy_o` = 0, `timeout_o` = 0, `txn_cnt_o` = 0, drop_cnt = 0.
  - All FIFO enables are 0.
  - `req_ready_o` = 1.
- **IDLE:**
  - `req_ready_o` = (drop_cnt != max).
  - On accept, register the request, set `status_o` = JTAG_AXI_RUNNING, clear `timeout_o`, go to ISSUE.
- **ISSUE, write:**
  - Requires `!fifo_txn_full_i && !fifo_wdata_full_i`.
  - Both pushes occur in the same cycle, or neither occurs.
  - Go to WAIT_RESP after the push.
- **ISSUE, read:** requires `!fifo_txn_full_i`; push the transaction FIFO only, then go to WAIT_RESP.
- **WAIT_RESP:**
  - The timer clears on entry and increments every cycle.
  - When `!fifo_resp_empty_i` and drop_cnt == 0: pop; next edge latch `status_o` ← `fifo_resp_i.status`.
  - On a read, `rdata_o` ← `data_rd`; on a write, `rdata_o` holds its previous value.
  - Increment `txn_cnt_o` and return to IDLE.
- **Timeout:**
  - Fires when the timer reaches `AXI_TIMEOUT_CYCLES-1` with no pop of the current response.
  - Set `status_o` = JTAG_AXI_TIMEOUT and `timeout_o` = 1, increment drop_cnt, return to IDLE.
  - `txn_cnt_o` is unchanged.
- **Discard (any state):**
  - When drop_cnt != 0 and `!fifo_resp_empty_i`: pop, decrement drop_cnt.
  - No output other than drop_cnt changes.
  - Discard has priority over capture.
- **Simultaneous events:**
  - Timeout and discard in the same cycle: drop_cnt net unchanged.
  - Current response valid on the timeout cycle with drop_cnt == 0: the response wins and no timeout is raised.
- **Counter limits:**
  - drop_cnt saturates at max. While saturated, `req_ready_o` = 0 and draining continues.
  - `txn_cnt_o` wraps 0xFFFF → 0.

## Timing
- Accept at edge N → FIFO push asserted combinationally in cycle N+1 if space; stall indefinitely while full.
- Earliest WAIT_RESP is N+2. The response pop is combinational in the first cycle `fifo_resp_empty_i` is low; outputs update at the following edge.
- Minimum request-to-IDLE is 3 cycles, and back-to-back accepts are possible every 3 cycles.
- `ares` mid-operation: immediate return to reset values. Entries already pushed stay in the FIFOs; clearing them is the owner's responsibility.

## Structure
- **Package `jtag_axi_pkg`:**
  - `jtag_axi_status_t` gains JTAG_AXI_IDLE, JTAG_AXI_RUNNING and JTAG_AXI_TIMEOUT alongside OKAY, EXOKAY, SLVERR and DECERR.
  - Default-timeout constant `JTAG_AXI_TIMEOUT_DEF` = 4096.
- FSM state enum is local to the module.
- No sub-module; the timer and drop counter are inline.

## Test plan
- **Read OKAY:**
  - Stimulus: read at 0x1000, size 2; bench returns `{0xDEADBEEF, OKAY}` 5 cycles later.
  - Required: exactly one transaction push with `txn_type` = 0, no wdata push; `status_o` = OKAY, `rdata_o` = 0xDEADBEEF, `txn_cnt_o` = 1.
- **Write with FIFOs full:**
  - Stimulus: write 0x20 / 0xA5A5A5A5 while `fifo_wdata_full_i` is high for 10 cycles.
  - Required: no push for 10 cycles, then both pushes in the same cycle; SLVERR response → `status_o` = SLVERR, `rdata_o` unchanged.
- **Timeout then late response:**
  - Stimulus: `AXI_TIMEOUT_CYCLES` = 16, no response.
  - Required: `status_o` = TIMEOUT and `timeout_o` = 1 after 16 WAIT_RESP cycles.
  - Next read is accepted; its stale response is discarded; its own `{0x55, OKAY}` is captured and `txn_cnt_o` increments by 1.
- **Saturation:**
  - Stimulus: 15 consecutive timeouts with `DROP_CNT_W` = 4.
  - Required: `req_ready_o` = 0; one response arrives → drop_cnt = 14 and `req_ready_o` returns to 1.
- **Race at timeout:** response valid exactly on the timeout cycle → OKAY captured, `timeout_o` stays 0.
- **Reset mid-flight:** assert `ares` in WAIT_RESP → all outputs at reset values in the same cycle, `req_ready_o` = 1 after release.

Source files
------------

// File: rtl/jtag_axi_pkg.sv
// Shared types and constants for the JTAG-to-AXI bridge request/response path.
package jtag_axi_pkg;

   localparam int unsigned JTAG_AXI_TIMEOUT_DEF = 4096;

   typedef logic [31:0] axi_addr_t;
   typedef logic [2:0]  axi_size_t;
   typedef logic [31:0] axi_data_t;

   typedef enum logic {
      AXI_TXN_READ  = 1'b0,
      AXI_TXN_WRITE = 1'b1
   } axi_txn_type_t;

   // Encodings 0..3 mirror AXI RESP so the response FIFO can carry BRESP/RRESP directly.
   typedef enum logic [2:0] {
      JTAG_AXI_OKAY    = 3'd0,
      JTAG_AXI_EXOKAY  = 3'd1,
      JTAG_AXI_SLVERR  = 3'd2,
      JTAG_AXI_DECERR  = 3'd3,
      JTAG_AXI_IDLE    = 3'd4,
      JTAG_AXI_RUNNING = 3'd5,
      JTAG_AXI_TIMEOUT = 3'd6
   } jtag_axi_status_t;

   typedef struct packed {
      axi_addr_t     addr;
      axi_size_t     size;
      axi_txn_type_t txn_type;
   } s_axi_afifo_to_axi_t;

   typedef struct packed {
      axi_data_t        data_rd;
      jtag_axi_status_t status;
   } s_axi_jtag_status_t;

endpackage

// File: rtl/jtag_axi_txn_ctrl.sv
// One-at-a-time JTAG request sequencer: push in cycle after accept (stalls while FIFOs full),
// wait for response or watchdog; responses of timed-out requests are drained and dropped.
module jtag_axi_txn_ctrl
   import jtag_axi_pkg::*;
#(
   parameter int unsigned AXI_TIMEOUT_CYCLES = JTAG_AXI_TIMEOUT_DEF,
   parameter int unsigned DROP_CNT_W         = 4
) (
   input  logic                clk,
   input  logic                ares,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  axi_addr_t           req_addr_i,
   input  axi_size_t           req_size_i,
   input  axi_data_t           req_data_i,
   input  logic                fifo_txn_full_i,
   output logic                fifo_txn_wr_en_o,
   output s_axi_afifo_to_axi_t fifo_txn_o,
   input  logic                fifo_wdata_full_i,
   output logic                fifo_wdata_wr_en_o,
   output axi_data_t           fifo_wdata_o,
   input  logic                fifo_resp_empty_i,
   input  s_axi_jtag_status_t  fifo_resp_i,
   output logic                fifo_resp_rd_en_o,
   output jtag_axi_status_t    status_o,
   output axi_data_t           rdata_o,
   output logic                busy_o,
   output logic                timeout_o,
   output logic [15:0]         txn_cnt_o
);

   localparam int unsigned TMR_W = (AXI_TIMEOUT_CYCLES > 1) ? $clog2(AXI_TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AXI_TIMEOUT_CYCLES - 1);
   localparam bit TMO_EN = (AXI_TIMEOUT_CYCLES != 0);
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RESP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   s_axi_afifo_to_axi_t req_q;
   axi_data_t           req_data_q;
   logic [TMR_W-1:0]    timer;
   logic [DROP_CNT_W-1:0] drop_cnt;

   logic accept;
   logic issue_ok;
   logic discard;
   logic capture;
   logic tmo_fire;

   always_ff @(posedge clk or posedge ares) begin
      if (ares) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt          = state;
      accept             = 1'b0;
      issue_ok           = 1'b0;
      capture            = 1'b0;
      tmo_fire           = 1'b0;
      req_ready_o        = 1'b0;
      // Stale responses belong to earlier timed-out requests and are always consumed first.
      discard            = (drop_cnt != '0) && !fifo_resp_empty_i;
      case (state)
         ST_IDLE: begin
            req_ready_o = (drop_cnt != DROP_MAX);
            if (req_valid_i && req_ready_o) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue_ok = !fifo_txn_full_i &&
                       ((req_q.txn_type == AXI_TXN_READ) || !fifo_wdata_full_i);
            if (issue_ok) begin
               state_nxt = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            capture  = (drop_cnt == '0) && !fifo_resp_empty_i;
            tmo_fire = TMO_EN && !capture && (timer == TMR_LAST);
            if (capture || tmo_fire) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      fifo_txn_wr_en_o   = issue_ok;
      fifo_wdata_wr_en_o = issue_ok && (req_q.txn_type == AXI_TXN_WRITE);
      fifo_resp_rd_en_o  = discard || capture;
      busy_o             = (state != ST_IDLE);
   end

   assign fifo_txn_o   = req_q;
   assign fifo_wdata_o = req_data_q;

   always_ff @(posedge clk or posedge ares) begin
      if (ares) begin
         req_q      <= '0;
         req_data_q <= '0;
         timer      <= '0;
         status_o   <= JTAG_AXI_IDLE;
         rdata_o    <= '0;
         timeout_o  <= 1'b0;
         txn_cnt_o  <= '0;
      end else begin
         if (accept) begin
            req_q.addr     <= req_addr_i;
            req_q.size     <= req_size_i;
            req_q.txn_type <= req_write_i ? AXI_TXN_WRITE : AXI_TXN_READ;
            req_data_q     <= req_data_i;
            status_o       <= JTAG_AXI_RUNNING;
            timeout_o      <= 1'b0;
         end
         if (issue_ok) begin
            timer <= '0;
         end else if (state == ST_WAIT_RESP) begin
            timer <= timer + TMR_W'(1);
         end
         if (capture) begin
            status_o  <= fifo_resp_i.status;
            txn_cnt_o <= txn_cnt_o + 16'd1;
            if (req_q.txn_type == AXI_TXN_READ) begin
               rdata_o <= fifo_resp_i.data_rd;
            end
         end
         if (tmo_fire) begin
            status_o  <= JTAG_AXI_TIMEOUT;
            timeout_o <= 1'b1;
         end
      end
   end

   // A timeout and a discard in the same cycle cancel out.
   always_ff @(posedge clk or posedge ares) begin
      if (ares) begin
         drop_cnt <= '0;
      end else begin
         case ({tmo_fire, discard})
            2'b10: if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            2'b01: drop_cnt <= drop_cnt - DROP_CNT_W'(1);
            default: drop_cnt <= drop_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Scoreboard bench: stimulus queues expected pushes/completions, a negedge monitor checks them.
module tb_jtag_axi_txn_ctrl;
   import jtag_axi_pkg::*;

   localparam int TMO      = 16;
   localparam int DROP_MAX = 15;

   logic                clk;
   logic                ares;
   logic                req_valid_i;
   logic                req_ready_o;
   logic                req_write_i;
   axi_addr_t           req_addr_i;
   axi_size_t           req_size_i;
   axi_data_t           req_data_i;
   logic                fifo_txn_full_i;
   logic                fifo_txn_wr_en_o;
   s_axi_afifo_to_axi_t fifo_txn_o;
   logic                fifo_wdata_full_i;
   logic                fifo_wdata_wr_en_o;
   axi_data_t           fifo_wdata_o;
   logic                fifo_resp_empty_i;
   s_axi_jtag_status_t  fifo_resp_i;
   logic                fifo_resp_rd_en_o;
   jtag_axi_status_t    status_o;
   axi_data_t           rdata_o;
   logic                busy_o;
   logic                timeout_o;
   logic [15:0]         txn_cnt_o;

   jtag_axi_txn_ctrl #(
      .AXI_TIMEOUT_CYCLES (TMO),
      .DROP_CNT_W         (4)
   ) dut (
      .clk                (clk),
      .ares               (ares),
      .req_valid_i        (req_valid_i),
      .req_ready_o        (req_ready_o),
      .req_write_i        (req_write_i),
      .req_addr_i         (req_addr_i),
      .req_size_i         (req_size_i),
      .req_data_i         (req_data_i),
      .fifo_txn_full_i    (fifo_txn_full_i),
      .fifo_txn_wr_en_o   (fifo_txn_wr_en_o),
      .fifo_txn_o         (fifo_txn_o),
      .fifo_wdata_full_i  (fifo_wdata_full_i),
      .fifo_wdata_wr_en_o (fifo_wdata_wr_en_o),
      .fifo_wdata_o       (fifo_wdata_o),
      .fifo_resp_empty_i  (fifo_resp_empty_i),
      .fifo_resp_i        (fifo_resp_i),
      .fifo_resp_rd_en_o  (fifo_resp_rd_en_o),
      .status_o           (status_o),
      .rdata_o            (rdata_o),
      .busy_o             (busy_o),
      .timeout_o          (timeout_o),
      .txn_cnt_o          (txn_cnt_o)
   );

   typedef struct {
      jtag_axi_status_t st;
      axi_data_t        rd;
      logic [15:0]      cnt;
      logic             tmo;
   } done_t;

   int n_cmp = 0;
   int n_bad = 0;

   s_axi_afifo_to_axi_t exp_txn_q[$];
   axi_data_t           exp_wd_q[$];
   done_t               exp_done_q[$];
   s_axi_jtag_status_t  resp_q[$];

   // Reference model: completed count, last read data, responses owed by timed-out requests.
   logic [15:0] m_cnt   = '0;
   axi_data_t   m_rdata = '0;
   int          owed    = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   task automatic push_stale();
      s_axi_jtag_status_t r;
      r.data_rd = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      r.status  = JTAG_AXI_DECERR;
      resp_q.push_back(r);
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #3;
         if (resp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("resp_fifo_drain");
   endtask

   // Response FIFO model: pops follow the DUT's read enable, head is presented after each edge.
   initial begin
      bit pop_now;
      fifo_resp_empty_i = 1'b1;
      fifo_resp_i       = '0;
      forever begin
         @(negedge clk);
         pop_now = fifo_resp_rd_en_o;
         @(posedge clk);
         #2;
         if (pop_now && resp_q.size() > 0) void'(resp_q.pop_front());
         fifo_resp_empty_i = (resp_q.size() == 0);
         fifo_resp_i       = (resp_q.size() == 0) ? '0 : resp_q[0];
      end
   end

   // Monitor
   initial begin
      bit                  prev_busy;
      s_axi_afifo_to_axi_t et;
      done_t               ed;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (ares) begin
            prev_busy = 1'b0;
            continue;
         end
         check("wdata_push_without_txn", 64'(fifo_wdata_wr_en_o & ~fifo_txn_wr_en_o), 64'(0));
         if (fifo_txn_wr_en_o) begin
            check("txn_push_while_full", 64'(fifo_txn_full_i), 64'(0));
            n_cmp++;
            if (exp_txn_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_txn_push: actual=%0h required=no push", fifo_txn_o);
            end else begin
               et = exp_txn_q.pop_front();
               check("txn_entry", 64'(fifo_txn_o), 64'(et));
               check("wdata_push_pairing", 64'(fifo_wdata_wr_en_o), 64'(et.txn_type));
               if (et.txn_type == AXI_TXN_WRITE && exp_wd_q.size() > 0) begin
                  check("wdata_push_while_full", 64'(fifo_wdata_full_i), 64'(0));
                  check("wdata_value", 64'(fifo_wdata_o), 64'(exp_wd_q.pop_front()));
               end
            end
         end
         if (busy_o && !prev_busy) begin
            check("accept_status", 64'(status_o), 64'(JTAG_AXI_RUNNING));
            check("accept_timeout_clr", 64'(timeout_o), 64'(0));
         end
         if (!busy_o && prev_busy) begin
            n_cmp++;
            if (exp_done_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_completion: actual=%0d required=none", status_o);
            end else begin
               ed = exp_done_q.pop_front();
               check("done_status", 64'(status_o), 64'(ed.st));
               check("done_rdata", 64'(rdata_o), 64'(ed.rd));
               check("done_txn_cnt", 64'(txn_cnt_o), 64'(ed.cnt));
               check("done_timeout", 64'(timeout_o), 64'(ed.tmo));
            end
         end
         prev_busy = busy_o;
      end
   end

   // dly: cycles after the push until our response is visible (0 = never answered).
   task automatic do_txn(input bit wr, input axi_addr_t addr, input axi_size_t size,
                         input axi_data_t wdata, input int dly, input jtag_axi_status_t rsp_st,
                         input axi_data_t rsp_dat, input int full_cyc, input bit full_wd);
      bit                  ok;
      bit                  hit;
      bit                  seen;
      done_t               d;
      s_axi_afifo_to_axi_t t;
      s_axi_jtag_status_t  r;
      if (owed == DROP_MAX) begin
         @(posedge clk);
         #1;
         push_stale();
         owed--;
         wait_drain();
      end
      ok = 1'b0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (req_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         bound_fail("req_ready_wait");
         return;
      end
      // Each owed stale entry ahead of ours costs one discard cycle inside the window.
      hit = (dly > 0) && (dly - 1 + owed <= TMO - 1);
      if (hit) begin
         m_cnt = m_cnt + 16'd1;
         if (!wr) m_rdata = rsp_dat;
         d = '{rsp_st, m_rdata, m_cnt, 1'b0};
      end else begin
         d = '{JTAG_AXI_TIMEOUT, m_rdata, m_cnt, 1'b1};
      end
      t.addr     = addr;
      t.size     = size;
      t.txn_type = wr ? AXI_TXN_WRITE : AXI_TXN_READ;
      exp_txn_q.push_back(t);
      if (wr) exp_wd_q.push_back(wdata);
      exp_done_q.push_back(d);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = addr;
      req_size_i  = size;
      req_data_i  = wdata;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      seen = 1'b0;
      fork
         begin
            if (full_cyc > 0) begin
               if (full_wd) fifo_wdata_full_i = 1'b1;
               else         fifo_txn_full_i   = 1'b1;
               repeat (full_cyc) @(posedge clk);
               #1;
               fifo_wdata_full_i = 1'b0;
               fifo_txn_full_i   = 1'b0;
            end
         end
         begin
            repeat (60) begin
               @(negedge clk);
               if (fifo_txn_wr_en_o) begin
                  seen = 1'b1;
                  break;
               end
            end
            if (!seen) begin
               bound_fail("txn_push_wait");
            end else if (hit) begin
               repeat (dly) @(posedge clk);
               #1;
               repeat (owed) push_stale();
               r.data_rd = rsp_dat;
               r.status  = rsp_st;
               resp_q.push_back(r);
               owed = 0;
            end
         end
      join
      if (!hit) owed++;
      ok = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (!busy_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("completion_wait");
      wait_drain();
      @(negedge clk);
      check("ready_vs_drop", 64'(req_ready_o), 64'(owed != DROP_MAX));
   endtask

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation exceeded its time budget");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      ares              = 1'b1;
      req_valid_i       = 1'b0;
      req_write_i       = 1'b0;
      req_addr_i        = '0;
      req_size_i        = '0;
      req_data_i        = '0;
      fifo_txn_full_i   = 1'b0;
      fifo_wdata_full_i = 1'b0;

      @(negedge clk);
      check("rst_status", 64'(status_o), 64'(JTAG_AXI_IDLE));
      check("rst_rdata", 64'(rdata_o), 64'(0));
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_timeout", 64'(timeout_o), 64'(0));
      check("rst_txn_cnt", 64'(txn_cnt_o), 64'(0));
      check("rst_txn_wr_en", 64'(fifo_txn_wr_en_o), 64'(0));
      check("rst_wdata_wr_en", 64'(fifo_wdata_wr_en_o), 64'(0));
      check("rst_resp_rd_en", 64'(fifo_resp_rd_en_o), 64'(0));
      check("rst_ready", 64'(req_ready_o), 64'(1));
      @(posedge clk);
      #1;
      ares = 1'b0;

      do_txn(1'b0, 32'h1000, 3'd2, 32'h0, 5, JTAG_AXI_OKAY, 32'hDEADBEEF, 0, 1'b0);
      do_txn(1'b1, 32'h20, 3'd2, 32'hA5A5A5A5, 3, JTAG_AXI_SLVERR, 32'h12345678, 10, 1'b1);
      do_txn(1'b0, 32'h40, 3'd2, 32'h0, 0, JTAG_AXI_OKAY, 32'h0, 0, 1'b0);
      do_txn(1'b0, 32'h44, 3'd2, 32'h0, 2, JTAG_AXI_OKAY, 32'h55, 0, 1'b0);
      do_txn(1'b0, 32'h80, 3'd2, 32'h0, TMO, JTAG_AXI_OKAY, 32'h77, 0, 1'b0);
      do_txn(1'b0, 32'h84, 3'd2, 32'h0, TMO + 1, JTAG_AXI_OKAY, 32'h78, 0, 1'b0);
      do_txn(1'b0, 32'h88, 3'd1, 32'h0, 1, JTAG_AXI_EXOKAY, 32'h99, 3, 1'b1);

      // Drive the drop counter to saturation.
      while (owed < DROP_MAX)
         do_txn(1'b0, 32'h100, 3'd2, 32'h0, 0, JTAG_AXI_OKAY, 32'h0, 0, 1'b0);
      check("saturated_ready", 64'(req_ready_o), 64'(0));
      @(posedge clk);
      #1;
      push_stale();
      owed--;
      wait_drain();
      @(negedge clk);
      check("desaturated_ready", 64'(req_ready_o), 64'(1));

      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 2)), $urandom,
                int'($urandom_range(0, 18)), jtag_axi_status_t'(3'($urandom_range(0, 3))),
                $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      // Reset while waiting for a response.
      do_txn(1'b0, 32'h200, 3'd2, 32'h0, 1, JTAG_AXI_OKAY, 32'hCAFE0001, 0, 1'b0);
      ok = 1'b0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (req_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("reset_test_ready");
      exp_txn_q.push_back('{32'h300, 3'd2, AXI_TXN_READ});
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h300;
      req_size_i  = 3'd2;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      @(posedge clk);
      #3;
      check("pre_reset_busy", 64'(busy_o), 64'(1));
      ares = 1'b1;
      #1;
      check("midrst_status", 64'(status_o), 64'(JTAG_AXI_IDLE));
      check("midrst_rdata", 64'(rdata_o), 64'(0));
      check("midrst_busy", 64'(busy_o), 64'(0));
      check("midrst_timeout", 64'(timeout_o), 64'(0));
      check("midrst_txn_cnt", 64'(txn_cnt_o), 64'(0));
      check("midrst_enables", 64'({fifo_txn_wr_en_o, fifo_wdata_wr_en_o, fifo_resp_rd_en_o}), 64'(0));
      m_cnt   = '0;
      m_rdata = '0;
      owed    = 0;
      resp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      ares = 1'b0;
      @(negedge clk);
      check("post_reset_ready", 64'(req_ready_o), 64'(1));

      do_txn(1'b0, 32'h400, 3'd2, 32'h0, 2, JTAG_AXI_OKAY, 32'h0BADF00D, 0, 1'b0);
      check("leftover_txn_expect", 64'(exp_txn_q.size()), 64'(0));
      check("leftover_done_expect", 64'(exp_done_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
